// File: rtl/clkgen_multi.sv
// Multi-channel glitch-free clock divider with per-channel start/stop/ratio FSM.
// Optional macro CLKGEN_PHASE_EN adds cfg_phase (start-phase offset on IDLE -> RUN).
module clkgen_ch #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             run_o
);
  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, r_q, r_d, pend_q, pend_d;
  logic             clk_q, clk_d, tick_q, tick_d;
  logic [DIV_W-1:0] eff;
  logic             wrap;

  always_comb begin
    eff     = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
    wrap    = (cnt_q == r_q - DIV_W'(1));
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    pend_d  = we_i ? eff : pend_q;
    case (state_q)
      IDLE: begin
        if (we_i && en_i) begin
          state_d = RUN;
          r_d     = eff;
          cnt_d   = (phase_i > eff - DIV_W'(1)) ? eff - DIV_W'(1) : phase_i;
        end
      end
      RUN, STOP_PEND: begin
        cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
        // New ratio only takes effect on a period boundary.
        if (wrap) r_d = pend_d;
        if (we_i) state_d = en_i ? RUN : STOP_PEND;
        if (state_d == STOP_PEND && wrap) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    clk_d  = (state_d != IDLE) && (cnt_d < r_d - (r_d >> 1));
    tick_d = (state_d != IDLE) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= DIV_W'(2);
      pend_q  <= DIV_W'(2);
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign run_o  = (state_q != IDLE);
endmodule

module clkgen_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
`ifdef CLKGEN_PHASE_EN
  input  logic [DIV_W-1:0]  cfg_phase,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] run
);
  logic [DIV_W-1:0] phase;
`ifdef CLKGEN_PHASE_EN
  assign phase = cfg_phase;
`else
  assign phase = '0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic we;
    // Indices >= NUM_CH match no lane and are dropped.
    assign we = cfg_we && (cfg_ch == CH_W'(g));
    clkgen_ch #(.DIV_W(DIV_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .we_i   (we),
      .en_i   (cfg_en),
      .div_i  (cfg_div),
      .phase_i(phase),
      .clk_o  (clk_out[g]),
      .tick_o (tick[g]),
      .run_o  (run[g])
    );
  end
endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi; phase-offset steps build only with CLKGEN_PHASE_EN.
module tb_clkgen_multi;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_en = 1'b0;
  logic [7:0] cfg_phase = '0;
  logic [3:0] clk_out, tick, run;
  int vectors = 0;
  int errs = 0;

  clkgen_multi #(.NUM_CH(4), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_en(cfg_en),
`ifdef CLKGEN_PHASE_EN
    .cfg_phase(cfg_phase),
`endif
    .clk_out(clk_out), .tick(tick), .run(run)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d, input logic en);
    cfg_ch = ch; cfg_div = d; cfg_en = en; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  p4 = 4'b0011;
  logic [4:0]  p5 = 5'b00111;
  logic [13:0] pc = 14'b00011100011100;
  logic [5:0]  pf = 6'b001100;

  initial begin
    // Reset state
    do_reset();
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_run", run, 0);

    // ch0 D=4, then ch1 D=5 while ch0 keeps running
    wr(0, 8'd4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("A_clk0", clk_out[0], p4[k%4]);
      chk("A_tick0", tick[0], (k%4) == 0);
      chk("A_run0", run[0], 1);
      step();
    end
    wr(1, 8'd5, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("A_clk1", clk_out[1], p5[k%5]);
      chk("A_tick1", tick[1], (k%5) == 0);
      chk("A_clk0_indep", clk_out[0], p4[(k+1)%4]);
      step();
    end

    // D=0 and D=1 both divide by 2; idle write with en=0 keeps outputs low
    do_reset();
    wr(2, 8'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("B_clk2_d0", clk_out[2], (k%2) == 0);
      chk("B_tick2_d0", tick[2], (k%2) == 0);
      step();
    end
    wr(2, 8'd1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("B_clk2_d1", clk_out[2], (k%2) == 1);
      step();
    end
    wr(3, 8'd7, 1'b0);
    chk("B_run_idle_wr", run, 4'b0100);
    chk("B_clk3_idle", clk_out[3], 0);

    // Ratio change 4 -> 6 written at cnt=1
    do_reset();
    wr(0, 8'd4, 1'b1);
    chk("C_clk_cnt0", clk_out[0], 1);
    step();
    chk("C_clk_cnt1", clk_out[0], 1);
    wr(0, 8'd6, 1'b1);
    for (int k = 0; k < 14; k++) begin
      chk("C_clk0", clk_out[0], pc[k]);
      chk("C_tick0", tick[0], (k == 2) || (k == 8));
      step();
    end

    // Stop at cnt=0 completes the period
    do_reset();
    wr(0, 8'd4, 1'b1);
    wr(0, 8'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("D_stop_clk", clk_out[0], k == 0);
      chk("D_stop_run", run[0], 1);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      chk("D_idle_clk", clk_out[0], 0);
      chk("D_idle_tick", tick[0], 0);
      chk("D_idle_run", run[0], 0);
      step();
    end
    // Stop cancelled at cnt=2: no gap
    wr(0, 8'd4, 1'b1);
    chk("D_restart_tick", tick[0], 1);
    wr(0, 8'd4, 1'b0);
    step();
    chk("D_cnt2_clk", clk_out[0], 0);
    wr(0, 8'd4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("D_cancel_clk", clk_out[0], p4[(k+3)%4]);
      chk("D_cancel_run", run[0], 1);
      step();
    end

    // Reset mid-period with simultaneous write
    do_reset();
    wr(0, 8'd4, 1'b1);
    wr(2, 8'd3, 1'b1);
    rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4; cfg_en = 1'b1;
    step();
    rst = 1'b0; cfg_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("E_clk", clk_out, 0);
      chk("E_tick", tick, 0);
      chk("E_run", run, 0);
      step();
    end

`ifdef CLKGEN_PHASE_EN
    // Start phase 2, then phase 9 clamped to R-1=3
    do_reset();
    cfg_phase = 8'd2;
    wr(0, 8'd4, 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("F_ph2_clk", clk_out[0], pf[k]);
      chk("F_ph2_tick", tick[0], k == 2);
      step();
    end
    do_reset();
    cfg_phase = 8'd9;
    wr(0, 8'd4, 1'b1);
    cfg_phase = 8'd0;
    for (int k = 0; k < 5; k++) begin
      chk("F_ph9_clk", clk_out[0], p4[(k+3)%4]);
      chk("F_ph9_tick", tick[0], ((k+3)%4) == 0);
      step();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
